multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//   Control FSM that sequences the shared RV32I datapath through fetch, decode, execute, memory and writeback.
//   One unified instruction/data memory sits behind a req/ready handshake.
//   It sits beside the combinational ALU decoder, which turns alu_op + funct3/funct7 into the ALU control.
//   A timeout watchdog on memory waits and sticky illegal-opcode detection drive a halt state.
// PARAMETERS
//   MEM_TIMEOUT  16  max cycles waiting for mem_ready before ERROR; 0 disables the watchdog
//   CW           5   width of the timeout counter; must satisfy 2^CW > MEM_TIMEOUT
// PORTS
//   clk          in   1  clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   opcode       in   7  instr[6:0] from the instruction register
//   branch_cond  in   1  comparator result for the current funct3 (1 = branch taken)
//   mem_ready    in   1  memory has completed the current access
//   mem_req      out  1  memory access request; held until mem_ready
//   mem_write    out  1  the request is a store
//   adr_src      out  1  memory address mux: 0 = PC, 1 = ALUOut
//   ir_write     out  1  latch instruction and OldPC
//   pc_write     out  1  PC <= result mux
//   reg_write    out  1  register file write
//   result_src   out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result
//   alu_src_a    out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero
//   alu_src_b    out  2  ALU B mux: 00 = RD2, 01 = ImmExt, 10 = const 4
//   alu_op       out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
//   imm_src      out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
//   illegal      out  1  sticky; set on unknown opcode or memory timeout
//   state_dbg    out  4  current state encoding
// BEHAVIOUR
//   - Reset: state <= FETCH, counter <= 0, illegal <= 0.
//     While rst_n = 0, every enable (mem_req, mem_write, ir_write, pc_write, reg_write) is forced to 0.
//     All mux selects are 0 during reset.
//   - Outputs are Moore decodes of state, except these, which are combinational on inputs:
//     pc_write/ir_write in FETCH (mem_ready), pc_write in BRANCH (branch_cond).
//   - Unlisted outputs are 0 in every state.
//   - States (state_dbg encoding) and per-state outputs:
//     0 FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
//       On mem_ready: ir_write=1, pc_write=1 (PC+4), go to DECODE. Otherwise stay.
//     1 DECODE: a=01, b=01, imm=010 (branch target -> ALUOut).
//       Dispatch on opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXEC_R, 0010011 -> EXEC_I,
//       1100011 -> BRANCH, 1101111 -> JAL, 1100111 -> JALR, 0110111 -> LUI, 0010111 -> AUIPC,
//       any other -> ERROR.
//     2 MEMADR: a=10, b=01, imm = I for loads / S for stores -> MEMREAD (load) or MEMWRITE (store).
//     3 MEMREAD: mem_req=1, adr_src=1; on mem_ready -> MEMWB.
//     4 MEMWB: result_src=01, reg_write=1 -> FETCH.
//     5 MEMWRITE: mem_req=1, mem_write=1, adr_src=1; on mem_ready -> FETCH.
//     6 EXEC_R: a=10, b=00, alu_op=10 -> ALUWB.
//     7 EXEC_I: a=10, b=01, imm=000, alu_op=10 -> ALUWB.
//     8 ALUWB: result_src=00, reg_write=1 -> FETCH.
//     9 BRANCH: a=10, b=00, alu_op=01, result_src=00; pc_write = branch_cond -> FETCH.
//     10 JAL: a=01, b=10, result_src=00, pc_write=1 (target from DECODE) -> ALUWB (rd = OldPC+4).
//     11 JALR: a=10, b=01, imm=000 -> JALR2.
//     12 JALR2: a=01, b=10, result_src=00, pc_write=1 -> ALUWB.
//     13 LUI: a=11, b=01, imm=100 -> ALUWB.
//     14 AUIPC: a=01, b=01, imm=100 -> ALUWB.
//     15 ERROR: illegal=1, all enables 0; exit only via reset.
//   - Watchdog: counter clears on entering FETCH, MEMREAD or MEMWRITE.
//     It increments each cycle those states wait with mem_ready = 0.
//     When MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with mem_ready = 0, go to ERROR.
//     mem_ready = 1 in the same cycle wins over the timeout.
//   - Counter saturates; it never wraps.
//   - mem_ready outside the memory states is ignored.
//   - Reset mid-access drops mem_req asynchronously; no partial writeback occurs.
// TESTING
//   1. addi (opcode 0010011), mem_ready = 1 every cycle -> FETCH, DECODE, EXEC_I, ALUWB, FETCH.
//      Exactly one reg_write pulse; pc_write pulses once, in FETCH.
//   2. lw, mem_ready low for 3 cycles in MEMREAD -> mem_req and adr_src = 1 held for 4 cycles.
//      Then MEMWB with result_src = 01 and reg_write = 1; 5 states total excluding waits.
//   3. beq with branch_cond = 0, then with branch_cond = 1 -> BRANCH pc_write = 0 and 1 respectively.
//      reg_write = 0 throughout both.
//   4. jalr -> JALR, JALR2 (pc_write = 1), ALUWB (reg_write = 1), FETCH; state_dbg = 11, 12, 8, 0.
//   5. MEM_TIMEOUT = 4, mem_ready held low in FETCH -> ERROR after 4 wait cycles.
//      illegal = 1 and stays set; mem_req = 0.
//      Repeat with mem_ready rising on cycle 4 -> DECODE, no error.
//   6. opcode 1111111 -> ERROR, illegal = 1. Assert rst_n = 0 mid-MEMWRITE -> mem_req/mem_write drop immediately.
//      After release: FETCH, illegal = 0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Memory-side handshake between the multicycle controller and the unified I/D memory.
// The controller is the master and raises requests; the memory answers with mem_ready.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM sequencing a shared RV32I datapath through fetch/decode/execute/memory/writeback,
// with a memory-wait watchdog and a sticky illegal flag that park the machine in ERROR.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CW          = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_controller_if.master        mem,
  input  logic [6:0]                     opcode,
  input  logic                           branch_cond,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic                           reg_write,
  output logic [1:0]                     result_src,
  output logic [1:0]                     alu_src_a,
  output logic [1:0]                     alu_src_b,
  output logic [1:0]                     alu_op,
  output logic [2:0]                     imm_src,
  output logic                           illegal,
  output logic [3:0]                     state_dbg
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [2:0] IMM_I      = 3'b000;
  localparam logic [2:0] IMM_S      = 3'b001;
  localparam logic [2:0] IMM_B      = 3'b010;
  localparam logic [2:0] IMM_U      = 3'b100;

  // Watchdog fires on the wait cycle that would bring the count up to MEM_TIMEOUT.
  localparam bit            WD_EN    = (MEM_TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ERROR    = 4'd15
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;

  logic          in_mem_state;
  logic          mem_wait;
  logic          timeout;

  logic          mem_req_c;
  logic          mem_write_c;
  logic          adr_src_c;
  logic          ir_write_c;
  logic          pc_write_c;
  logic          reg_write_c;
  logic [1:0]    result_src_c;
  logic [1:0]    alu_src_a_c;
  logic [1:0]    alu_src_b_c;
  logic [1:0]    alu_op_c;
  logic [2:0]    imm_src_c;

  // Next-state, watchdog counter and sticky illegal flag.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    illegal_d    = illegal_q;
    in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    mem_wait     = in_mem_state && !mem.mem_ready;
    timeout      = WD_EN && mem_wait && (cnt_q == CNT_LAST);

    case (state_q)
      S_FETCH: begin
        if (mem.mem_ready)  state_d = S_DECODE;
        else if (timeout)   state_d = S_ERROR;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_ALUR:           state_d = S_EXEC_R;
          OP_ALUI:           state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_ERROR;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem.mem_ready)  state_d = S_MEMWB;
        else if (timeout)   state_d = S_ERROR;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem.mem_ready)  state_d = S_FETCH;
        else if (timeout)   state_d = S_ERROR;
      end
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALR2;
      S_JALR2:    state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      default:    state_d = S_ERROR;
    endcase

    // Any state change restarts the count, so every memory state is entered at zero.
    if (state_d != state_q)              cnt_d = '0;
    else if (mem_wait && cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);

    if (state_d == S_ERROR) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Per-state control decode; reset overrides everything so an access in flight drops at once.
  always_comb begin
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    result_src_c = RES_ALUOUT;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RD2;
    alu_op_c     = ALU_ADD;
    imm_src_c    = IMM_I;

    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALU;
        ir_write_c   = mem.mem_ready;
        pc_write_c   = mem.mem_ready;
      end
      S_DECODE: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_B;
      end
      S_MEMADR: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
      end
      S_MEMWB: begin
        result_src_c = RES_MEM;
        reg_write_c  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_RD2;
        alu_op_c    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_I;
        alu_op_c    = ALU_FUNCT;
      end
      S_ALUWB: begin
        result_src_c = RES_ALUOUT;
        reg_write_c  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_c  = SRCA_RD1;
        alu_src_b_c  = SRCB_RD2;
        alu_op_c     = ALU_SUB;
        result_src_c = RES_ALUOUT;
        pc_write_c   = branch_cond;
      end
      S_JAL, S_JALR2: begin
        alu_src_a_c  = SRCA_OLDPC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALUOUT;
        pc_write_c   = 1'b1;
      end
      S_JALR: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_I;
      end
      S_LUI: begin
        alu_src_a_c = SRCA_ZERO;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_U;
      end
      S_AUIPC: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_U;
      end
      default: ;
    endcase

    if (!rst_n) begin
      mem_req_c    = 1'b0;
      mem_write_c  = 1'b0;
      adr_src_c    = 1'b0;
      ir_write_c   = 1'b0;
      pc_write_c   = 1'b0;
      reg_write_c  = 1'b0;
      result_src_c = '0;
      alu_src_a_c  = '0;
      alu_src_b_c  = '0;
      alu_op_c     = '0;
      imm_src_c    = '0;
    end
  end

  assign mem.mem_req   = mem_req_c;
  assign mem.mem_write = mem_write_c;
  assign mem.adr_src   = adr_src_c;
  assign ir_write      = ir_write_c;
  assign pc_write      = pc_write_c;
  assign reg_write     = reg_write_c;
  assign result_src    = result_src_c;
  assign alu_src_a     = alu_src_a_c;
  assign alu_src_b     = alu_src_b_c;
  assign alu_op        = alu_op_c;
  assign imm_src       = imm_src_c;
  assign illegal       = illegal_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction walks, memory waits, watchdog and reset.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_cond;

  logic       ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state_dbg;

  logic       nw_ir_write, nw_pc_write, nw_reg_write, nw_illegal;
  logic [1:0] nw_result_src, nw_alu_src_a, nw_alu_src_b, nw_alu_op;
  logic [2:0] nw_imm_src;
  logic [3:0] nw_state_dbg;

  int n_tests;
  int n_fail;

  multicycle_controller_if bus ();
  multicycle_controller_if bus_nw ();

  multicycle_controller #(.MEM_TIMEOUT(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .mem(bus), .opcode(opcode), .branch_cond(branch_cond),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_src(imm_src), .illegal(illegal), .state_dbg(state_dbg)
  );

  multicycle_controller #(.MEM_TIMEOUT(0), .CW(2)) dut_nw (
    .clk(clk), .rst_n(rst_n), .mem(bus_nw), .opcode(opcode), .branch_cond(branch_cond),
    .ir_write(nw_ir_write), .pc_write(nw_pc_write), .reg_write(nw_reg_write),
    .result_src(nw_result_src), .alu_src_a(nw_alu_src_a), .alu_src_b(nw_alu_src_b),
    .alu_op(nw_alu_op), .imm_src(nw_imm_src), .illegal(nw_illegal), .state_dbg(nw_state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    rst_n = 1'b0; opcode = OP_ALUI; branch_cond = 1'b0;
    bus.mem_ready = 1'b1; bus_nw.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs = {bus.mem_req, bus.mem_write, bus.adr_src, ir_write, pc_write, reg_write,
            result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal};
    n_tests++;
    if (outs !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected all zero", outs);
    end
    n_tests++;
    if (state_dbg !== 4'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({bus.mem_req, bus.adr_src, alu_src_a, alu_src_b, result_src, ir_write, pc_write}
        !== {1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL fetch_after_reset: got req=%b adr=%b a=%b b=%b res=%b ir=%b pc=%b expected 1 0 00 10 10 1 1",
               bus.mem_req, bus.adr_src, alu_src_a, alu_src_b, result_src, ir_write, pc_write);
    end
  endtask

  task automatic test_addi();
    int st [4] = '{0, 1, 7, 8};
    int n_pc = 0;
    int n_rw = 0;
    opcode = OP_ALUI;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b1;
      #1;
      n_tests++;
      if (state_dbg !== 4'(st[i])) begin
        n_fail++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]);
      end
      if (i == 1) begin
        n_tests++;
        if ({alu_src_a, alu_src_b, imm_src} !== {2'b01, 2'b01, 3'b010}) begin
          n_fail++; $display("FAIL decode_muxes: got a=%b b=%b imm=%b expected 01 01 010", alu_src_a, alu_src_b, imm_src);
        end
      end
      if (i == 2) begin
        n_tests++;
        if ({alu_src_a, alu_src_b, alu_op, imm_src} !== {2'b10, 2'b01, 2'b10, 3'b000}) begin
          n_fail++; $display("FAIL exec_i_muxes: got a=%b b=%b op=%b imm=%b expected 10 01 10 000",
                             alu_src_a, alu_src_b, alu_op, imm_src);
        end
      end
      if (pc_write) n_pc++;
      if (reg_write) n_rw++;
      tick();
    end
    n_tests++;
    if (n_pc != 1 || n_rw != 1) begin
      n_fail++; $display("FAIL addi_pulses: got pc_write=%0d reg_write=%0d expected 1 1", n_pc, n_rw);
    end
  endtask

  task automatic test_load();
    int st  [8] = '{0, 1, 2, 3, 3, 3, 3, 4};
    int rdy [8] = '{1, 0, 0, 0, 0, 0, 1, 0};
    int n_adr = 0;
    opcode = OP_LOAD;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rdy[i][0];
      #1;
      n_tests++;
      if (state_dbg !== 4'(st[i])) begin
        n_fail++; $display("FAIL load_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]);
      end
      if (bus.mem_req && bus.adr_src) n_adr++;
      if (i == 7) begin
        n_tests++;
        if ({result_src, reg_write} !== {2'b01, 1'b1}) begin
          n_fail++; $display("FAIL memwb: got res=%b rw=%b expected 01 1", result_src, reg_write);
        end
      end
      tick();
    end
    n_tests++;
    if (n_adr != 4) begin
      n_fail++; $display("FAIL load_req_hold: got %0d cycles expected 4", n_adr);
    end
  endtask

  task automatic test_store();
    int st  [5] = '{0, 1, 2, 5, 5};
    int rdy [5] = '{1, 0, 0, 0, 1};
    int n_wr = 0;
    int n_rw = 0;
    opcode = OP_STORE;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rdy[i][0];
      #1;
      n_tests++;
      if (state_dbg !== 4'(st[i])) begin
        n_fail++; $display("FAIL store_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]);
      end
      if (i == 2) begin
        n_tests++;
        if (imm_src !== 3'b001) begin
          n_fail++; $display("FAIL store_imm: got %b expected 001", imm_src);
        end
      end
      if (bus.mem_write && bus.mem_req && bus.adr_src) n_wr++;
      if (reg_write) n_rw++;
      tick();
    end
    n_tests++;
    if (n_wr != 2 || n_rw != 0) begin
      n_fail++; $display("FAIL store_pulses: got write=%0d rw=%0d expected 2 0", n_wr, n_rw);
    end
  endtask

  task automatic test_branch();
    int st [3] = '{0, 1, 9};
    int n_rw = 0;
    opcode = OP_BRANCH;
    for (int t = 0; t < 2; t++) begin
      branch_cond = 1'(t);
      for (int i = 0; i < 3; i++) begin
        bus.mem_ready = (i == 0);
        #1;
        n_tests++;
        if (state_dbg !== 4'(st[i])) begin
          n_fail++; $display("FAIL branch%0d_state[%0d]: got %0d expected %0d", t, i, state_dbg, st[i]);
        end
        n_tests++;
        if (pc_write !== ((i == 0) ? 1'b1 : (i == 2) ? 1'(t) : 1'b0)) begin
          n_fail++; $display("FAIL branch%0d_pc_write[%0d]: got %b", t, i, pc_write);
        end
        if (i == 2) begin
          n_tests++;
          if (alu_op !== 2'b01) begin
            n_fail++; $display("FAIL branch_alu_op: got %b expected 01", alu_op);
          end
        end
        if (reg_write) n_rw++;
        tick();
      end
    end
    branch_cond = 1'b0;
    n_tests++;
    if (n_rw != 0) begin
      n_fail++; $display("FAIL branch_reg_write: got %0d pulses expected 0", n_rw);
    end
  endtask

  task automatic test_jump();
    int st_r [5] = '{0, 1, 11, 12, 8};
    int pc_r [5] = '{1, 0, 0, 1, 0};
    int rw_r [5] = '{0, 0, 0, 0, 1};
    int st_j [4] = '{0, 1, 10, 8};
    int pc_j [4] = '{1, 0, 1, 0};
    int rw_j [4] = '{0, 0, 0, 1};
    opcode = OP_JALR;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = (i == 0);
      #1;
      n_tests++;
      if ({state_dbg, pc_write, reg_write} !== {4'(st_r[i]), pc_r[i][0], rw_r[i][0]}) begin
        n_fail++; $display("FAIL jalr[%0d]: got st=%0d pc=%b rw=%b expected st=%0d pc=%0d rw=%0d",
                           i, state_dbg, pc_write, reg_write, st_r[i], pc_r[i], rw_r[i]);
      end
      tick();
    end
    opcode = OP_JAL;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 0);
      #1;
      n_tests++;
      if ({state_dbg, pc_write, reg_write} !== {4'(st_j[i]), pc_j[i][0], rw_j[i][0]}) begin
        n_fail++; $display("FAIL jal[%0d]: got st=%0d pc=%b rw=%b expected st=%0d pc=%0d rw=%0d",
                           i, state_dbg, pc_write, reg_write, st_j[i], pc_j[i], rw_j[i]);
      end
      if (i == 2) begin
        n_tests++;
        if ({alu_src_a, alu_src_b, result_src} !== {2'b01, 2'b10, 2'b00}) begin
          n_fail++; $display("FAIL jal_muxes: got a=%b b=%b res=%b expected 01 10 00", alu_src_a, alu_src_b, result_src);
        end
      end
      tick();
    end
  endtask

  task automatic test_upper();
    logic [6:0] exp_mux [2] = '{7'b11_01_100, 7'b01_01_100};
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? OP_LUI : OP_AUIPC;
      for (int i = 0; i < 4; i++) begin
        bus.mem_ready = (i == 0);
        #1;
        n_tests++;
        if (state_dbg !== ((i == 2) ? 4'(13 + k) : (i == 3) ? 4'd8 : 4'(i))) begin
          n_fail++; $display("FAIL upper%0d_state[%0d]: got %0d", k, i, state_dbg);
        end
        if (i == 2) begin
          n_tests++;
          if ({alu_src_a, alu_src_b, imm_src} !== exp_mux[k]) begin
            n_fail++; $display("FAIL upper%0d_muxes: got %b expected %b", k, {alu_src_a, alu_src_b, imm_src}, exp_mux[k]);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_timeout();
    int st  [7] = '{0, 0, 0, 0, 1, 7, 8};
    int rdy [7] = '{0, 0, 0, 1, 0, 0, 0};
    opcode = OP_ALUI;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b0;
      #1;
      n_tests++;
      if ({state_dbg, bus.mem_req} !== {4'd0, 1'b1}) begin
        n_fail++; $display("FAIL timeout_wait[%0d]: got st=%0d req=%b expected 0 1", i, state_dbg, bus.mem_req);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'(i > 0);
      #1;
      n_tests++;
      if ({state_dbg, illegal, bus.mem_req, pc_write, ir_write} !== {4'd15, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL timeout_error[%0d]: got st=%0d ill=%b req=%b pc=%b ir=%b expected 15 1 0 0 0",
                           i, state_dbg, illegal, bus.mem_req, pc_write, ir_write);
      end
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = rdy[i][0];
      #1;
      n_tests++;
      if ({state_dbg, illegal} !== {4'(st[i]), 1'b0}) begin
        n_fail++; $display("FAIL ready_on_last[%0d]: got st=%0d ill=%b expected %0d 0", i, state_dbg, illegal, st[i]);
      end
      tick();
    end
  endtask

  task automatic test_illegal_reset();
    int st [4] = '{0, 1, 2, 5};
    opcode = 7'b1111111;
    bus.mem_ready = 1'b1;
    #1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    n_tests++;
    if ({state_dbg, illegal} !== {4'd15, 1'b1}) begin
      n_fail++; $display("FAIL bad_opcode: got st=%0d ill=%b expected 15 1", state_dbg, illegal);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    opcode = OP_STORE;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 0);
      #1;
      n_tests++;
      if (state_dbg !== 4'(st[i])) begin
        n_fail++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]);
      end
      if (i < 3) tick();
    end
    n_tests++;
    if ({bus.mem_req, bus.mem_write, bus.adr_src} !== 3'b111) begin
      n_fail++; $display("FAIL memwrite_active: got %b expected 111", {bus.mem_req, bus.mem_write, bus.adr_src});
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_req, bus.mem_write, bus.adr_src, state_dbg} !== {3'b000, 4'd0}) begin
      n_fail++; $display("FAIL async_drop: got req=%b wr=%b adr=%b st=%0d expected 0 0 0 0",
                         bus.mem_req, bus.mem_write, bus.adr_src, state_dbg);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({state_dbg, illegal, bus.mem_req, reg_write} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL after_release: got st=%0d ill=%b req=%b rw=%b expected 0 0 1 0",
                         state_dbg, illegal, bus.mem_req, reg_write);
    end
  endtask

  task automatic test_no_watchdog();
    bus.mem_ready = 1'b0;
    bus_nw.mem_ready = 1'b0;
    repeat (20) tick();
    n_tests++;
    if ({nw_state_dbg, nw_illegal, bus_nw.mem_req} !== {4'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL no_watchdog: got st=%0d ill=%b req=%b expected 0 0 1",
                         nw_state_dbg, nw_illegal, bus_nw.mem_req);
    end
    n_tests++;
    if ({state_dbg, illegal} !== {4'd15, 1'b1}) begin
      n_fail++; $display("FAIL watchdog_long_wait: got st=%0d ill=%b expected 15 1", state_dbg, illegal);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_addi();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_upper();
    test_timeout();
    test_illegal_reset();
    test_no_watchdog();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish, got no end expected finish");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
